logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the 8-bit AND/OR/NOT unit.
- Computes one of eight bitwise operations on two WIDTH-bit operands and adds zero and parity flags.
- Operands enter through a valid/ready handshake. Results leave through a 2-entry output skid buffer, so back-pressure never creates a combinational path from out_ready to in_ready.
- Sits between the operand mux and the ALU result bus, alongside the adder blocks.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept an operand transaction.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select, sampled with a and b.
- out_valid  output  1  result at head of buffer valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- zero  output  1  high when s is all zeros.
- parity  output  1  XOR-reduction of s (1 = odd number of ones).

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Op codes:
  - 000 a&b
  - 001 a|b
  - 010 ~a (b ignored)
  - 011 ~(a&b), a true NAND
  - 100 ~(a|b)
  - 101 a^b
  - 110 ~(a^b)
  - 111 a (pass)
- All results are exactly WIDTH bits. No carry or overflow.
- Accept when in_valid && in_ready at a rising edge. The result and flags are computed combinationally from a, b, op and written into the buffer on that edge.
- Latency is 1 cycle: when the buffer is empty, out_valid rises the cycle after acceptance.
- Pop when out_valid && out_ready at a rising edge.
- Buffer holds 0, 1 or 2 entries (count register). FIFO order is strict. s, zero and parity always show the head entry.
- in_ready = (count != 2). It is decoded from the count register only and never depends on out_ready or in_valid in the same cycle.
- out_valid = (count != 0).
- Simultaneous events:
  - count 0, accept: count goes to 1.
  - count 1, accept and pop: count stays 1, the new entry becomes the head.
  - count 1, pop only: count goes to 0.
  - count 2: accept is impossible. A pop drops count to 1 and in_ready rises the next cycle.
- While out_valid is high and out_ready is low, s, zero and parity hold stable. The consumer may rely on this.
- When out_valid is low, s, zero and parity read 0. Empty or popped slots are never exposed.
- in_valid with in_ready low: the transaction is not taken. The producer must hold a, b and op until it is accepted.
- Reset, at any time including mid-transaction, asynchronously clears:
  - count to 0, out_valid 0, in_ready 1
  - both buffer entries to 0, so s 0, zero 0, parity 0
  - In-flight results are discarded.
  - The first accept is possible on the first rising edge with rst_n high.
- Operands with X/Z bits are not supported. The block does not detect them.

Test Plan:
- Reset: assert rst_n=0 mid-stream holding 2 entries -> out_valid=0, in_ready=1, s=0, zero=0, parity=0 immediately, without waiting for a clock edge.
- Op sweep (WIDTH=8, a=8'hC5, b=8'h3C, out_ready=1), one op per cycle, in order 000 to 111 -> s sequence 04, FD, 3A, FB, 02, F9, 06, C5. Each appears one cycle after accept. Parity 1,1,0,1,1,0,0,0. Zero 0 throughout.
- Zero flag: op=000, a=8'hF0, b=8'h0F -> s=00, zero=1, parity=0.
- Back-pressure: out_ready=0, offer 3 transactions back to back -> first two accepted, in_ready=0 from the cycle after the second accept, s holds the first result. Raise out_ready for one cycle -> first popped, in_ready=1 next cycle, third accepted. Results emerge in original order.
- Simultaneous accept and pop at count=1, over 10 consecutive cycles -> count stays 1, one result per cycle, no loss or duplication.
- Width: WIDTH=1 and WIDTH=32 builds, random ops and operands over 1000 transactions with random in_valid/out_ready -> scoreboard matches a bitwise reference model. zero and parity match the reductions of s.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with zero/parity flags.
// Valid/ready input, 2-entry output skid buffer, 1-cycle latency.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             parity
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             z;
    logic             p;
  } ent_t;

  ent_t       res;
  logic [WIDTH-1:0] r;
  ent_t       e0_q, e0_d;
  ent_t       e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  // Operation decode and flag generation for the incoming operands
  always_comb begin
    r = '0;
    unique case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = ~a;
      3'b011: r = ~(a & b);
      3'b100: r = ~(a | b);
      3'b101: r = a ^ b;
      3'b110: r = ~(a ^ b);
      3'b111: r = a;
      default: r = '0;
    endcase
    res.s = r;
    res.z = (r == '0);
    res.p = ^r;
  end

  // Handshake decoded from the count register only
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // e0 is the head; e1 stays zero unless two entries are held
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = res;
        else               e1_d = res;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        e1_d  = '0;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        e0_d = res;
      end
      default: ;
    endcase
  end

  // Buffer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign s      = e0_q.s;
  assign zero   = e0_q.z;
  assign parity = e0_q.p;

endmodule
